// File: rtl/instr_realigner.sv
// -----------------------------------------------------------------------------
// instr_realigner
//   Fetch-side realignment buffer. Takes word-aligned 32-bit fetch words and
//   presents one halfword-aligned raw instruction per cycle, with its PC, to the
//   compressed decoder. A 32-bit instruction may straddle two fetch words. A
//   redirect flushes the buffer. Words whose address does not match the next
//   needed word are accepted and dropped.
//
//   Configuration macro: REALIGNER_RVC_EN
//     defined   : RVC (16-bit) instructions are recognised and popped singly.
//     undefined : every instruction is 32-bit and all PCs are word-aligned.
//
//   Ports
//     clk_i            clock
//     rst_ni           asynchronous active-low reset
//     fetch_valid_i    fetch word present
//     fetch_pc_i       fetch word address ([1:0] ignored)
//     fetch_rdata_i    fetch word, little-endian halfwords
//     fetch_ready_o    buffer can take a word this cycle
//     instr_valid_o    instr_o holds a complete instruction
//     instr_o          raw instruction {hw[1], hw[0]}
//     instr_pc_o       PC of instr_o
//     is_compressed_o  instr_o is RVC (qualified by instr_valid_o)
//     instr_ready_i    downstream accepts instr_o
//     redirect_i       flush and restart at redirect_pc_i
//     redirect_pc_i    new PC (bit 0 ignored)
// -----------------------------------------------------------------------------
module instr_realigner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        is_compressed_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

`ifdef REALIGNER_RVC_EN
    localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:1], 1'b0};
`else
    localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};
`endif

    logic [15:0] r_hw [4];
    logic [2:0]  r_cnt;
    logic [31:0] r_head_pc;
    logic [29:0] r_exp_word;

    logic        w_drop_low;
    logic        w_hw0_rvc;
    logic        w_instr_avail;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_pop_n;
    logic [2:0]  w_push_n;
    logic [2:0]  w_base;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] w_head_pc_nxt;
    logic [31:0] w_redirect_pc;
    logic [15:0] w_hw_nxt [4];
    logic        w_unused_bits;

`ifdef REALIGNER_RVC_EN
    logic r_drop_low;
    assign w_drop_low    = r_drop_low;
    assign w_hw0_rvc     = (r_hw[0][1:0] != 2'b11);
    assign w_redirect_pc = {redirect_pc_i[31:1], 1'b0};
`else
    assign w_drop_low    = 1'b0;
    assign w_hw0_rvc     = 1'b0;
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
`endif

    // Low address bits are irrelevant to the word match; keep them visibly sunk.
    assign w_unused_bits = ^{fetch_pc_i[1:0], redirect_pc_i[1:0]};

    // Readiness looks only at the registered count so fetch never waits on
    // the downstream stall path.
    assign fetch_ready_o   = (r_cnt <= 3'd2) | redirect_i;
    assign w_instr_avail   = ((r_cnt >= 3'd1) & w_hw0_rvc) | (r_cnt >= 3'd2);
    assign instr_valid_o   = ~redirect_i & w_instr_avail;
    assign instr_o         = {r_hw[1], r_hw[0]};
    assign instr_pc_o      = r_head_pc;
    assign is_compressed_o = instr_valid_o & w_hw0_rvc;

    assign w_push   = fetch_valid_i & fetch_ready_o & ~redirect_i &
                      (fetch_pc_i[31:2] == r_exp_word);
    assign w_pop    = instr_valid_o & instr_ready_i;
    assign w_pop_n  = ~w_pop  ? 3'd0 : (w_hw0_rvc  ? 3'd1 : 3'd2);
    assign w_push_n = ~w_push ? 3'd0 : (w_drop_low ? 3'd1 : 3'd2);

    // Tail position after the pop; a push is only possible with cnt <= 2,
    // so the appended halfwords always land within hw[0..3].
    assign w_base        = r_cnt - w_pop_n;
    assign w_cnt_nxt     = w_base + w_push_n;
    assign w_head_pc_nxt = r_head_pc + {28'd0, w_pop_n, 1'b0};

    // Shift out the popped halfwords first, then append at the new tail.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_hw_nxt[i] = r_hw[i];
        end
        if (w_pop_n == 3'd1) begin
            w_hw_nxt[0] = r_hw[1];
            w_hw_nxt[1] = r_hw[2];
            w_hw_nxt[2] = r_hw[3];
        end else if (w_pop_n == 3'd2) begin
            w_hw_nxt[0] = r_hw[2];
            w_hw_nxt[1] = r_hw[3];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_push && (i == 32'(w_base))) begin
                w_hw_nxt[i] = w_drop_low ? fetch_rdata_i[31:16] : fetch_rdata_i[15:0];
            end
            if (w_push && !w_drop_low && (i == 32'(w_base) + 32'd1)) begin
                w_hw_nxt[i] = fetch_rdata_i[31:16];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_hw[i] <= '0;
            end
            r_cnt      <= '0;
            r_head_pc  <= BOOT_PC;
            r_exp_word <= BOOT_ADDR[31:2];
`ifdef REALIGNER_RVC_EN
            r_drop_low <= BOOT_ADDR[1];
`endif
        end else if (redirect_i) begin
            r_cnt      <= '0;
            r_head_pc  <= w_redirect_pc;
            r_exp_word <= redirect_pc_i[31:2];
`ifdef REALIGNER_RVC_EN
            r_drop_low <= redirect_pc_i[1];
`endif
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_hw[i] <= w_hw_nxt[i];
            end
            r_cnt     <= w_cnt_nxt;
            r_head_pc <= w_head_pc_nxt;
            if (w_push) begin
                r_exp_word <= r_exp_word + 30'd1;
`ifdef REALIGNER_RVC_EN
                r_drop_low <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_realigner.sv
// -----------------------------------------------------------------------------
// tb_instr_realigner
//   Directed bench for instr_realigner with hand-computed expectations. Where
//   behaviour differs with REALIGNER_RVC_EN, expected values select per build.
// -----------------------------------------------------------------------------
module tb_instr_realigner;

`ifdef REALIGNER_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        is_compressed_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int n_checks;
    int n_errors;

    instr_realigner #(.BOOT_ADDR(32'h0000_0000)) u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_pc_i      (fetch_pc_i),
        .fetch_rdata_i   (fetch_rdata_i),
        .fetch_ready_o   (fetch_ready_o),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .is_compressed_o (is_compressed_o),
        .instr_ready_i   (instr_ready_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to the next cycle, then drive that cycle's inputs.
    task automatic set(input logic fv, input logic [31:0] fpc, input logic [31:0] fdata,
                       input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk_i);
        #1;
        fetch_valid_i = fv;
        fetch_pc_i    = fpc;
        fetch_rdata_i = fdata;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_ni        = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_pc_i    = '0;
        fetch_rdata_i = '0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        // Reset state
        #2;
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        check("rst_comp", {31'd0, is_compressed_o}, 32'd0);
        check("rst_fready", {31'd0, fetch_ready_o}, 32'd1);
        #8 rst_ni = 1'b1;

        // Aligned 32-bit stream
        set(1, 32'h0, 32'h0050_0093, 1, 0, 0);
        check("al_v0", {31'd0, instr_valid_o}, 32'd0);
        set(1, 32'h4, 32'h00A0_0113, 1, 0, 0);
        check("al_v1", {31'd0, instr_valid_o}, 32'd1);
        check("al_i1", instr_o, 32'h0050_0093);
        check("al_pc1", instr_pc_o, 32'h0);
        check("al_c1", {31'd0, is_compressed_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("al_i2", instr_o, 32'h00A0_0113);
        check("al_pc2", instr_pc_o, 32'h4);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("al_v3", {31'd0, instr_valid_o}, 32'd0);

        // Straddling instruction
        set(0, 32'h0, 32'h0, 1, 1, 32'h0);
        check("st_rdv", {31'd0, instr_valid_o}, 32'd0);
        check("st_rdr", {31'd0, fetch_ready_o}, 32'd1);
        set(1, 32'h0, 32'h0093_4501, 1, 0, 0);
        check("st_v0", {31'd0, instr_valid_o}, 32'd0);
        set(1, 32'h4, 32'h0000_0010, 1, 0, 0);
        check("st_v1", {31'd0, instr_valid_o}, 32'd1);
        check("st_i1", instr_o, 32'h0093_4501);
        check("st_pc1", instr_pc_o, 32'h0);
        check("st_c1", {31'd0, is_compressed_o}, {31'd0, RVC});
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("st_i2", instr_o, RVC ? 32'h0010_0093 : 32'h0000_0010);
        check("st_pc2", instr_pc_o, RVC ? 32'h2 : 32'h4);
        check("st_c2", {31'd0, is_compressed_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("st_v3", {31'd0, instr_valid_o}, {31'd0, RVC});
        check("st_pc3", instr_pc_o, RVC ? 32'h6 : 32'h8);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("st_v4", {31'd0, instr_valid_o}, 32'd0);

        // Misaligned redirect
        set(0, 32'h0, 32'h0, 1, 1, 32'h102);
        check("mr_rdv", {31'd0, instr_valid_o}, 32'd0);
        set(1, 32'h100, 32'h4585_4501, 1, 0, 0);
        check("mr_v0", {31'd0, instr_valid_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("mr_v1", {31'd0, instr_valid_o}, 32'd1);
        check("mr_lo", {16'd0, instr_o[15:0]}, RVC ? 32'h4585 : 32'h4501);
        check("mr_pc", instr_pc_o, RVC ? 32'h102 : 32'h100);
        check("mr_c", {31'd0, is_compressed_o}, {31'd0, RVC});
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("mr_v2", {31'd0, instr_valid_o}, 32'd0);

        // Stale-word discard, redirect masking buffered data
        set(1, 32'h104, 32'h0000_0013, 0, 0, 0);
        check("sw_v0", {31'd0, instr_valid_o}, 32'd0);
        set(1, 32'h80, 32'h0000_0013, 0, 1, 32'h200);
        check("sw_rdv", {31'd0, instr_valid_o}, 32'd0);
        check("sw_rdr", {31'd0, fetch_ready_o}, 32'd1);
        set(1, 32'h80, 32'h0000_0013, 1, 0, 0);
        check("sw_r80", {31'd0, fetch_ready_o}, 32'd1);
        check("sw_v80", {31'd0, instr_valid_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("sw_vdrop", {31'd0, instr_valid_o}, 32'd0);
        set(1, 32'h200, 32'h0000_0013, 1, 0, 0);
        check("sw_v200a", {31'd0, instr_valid_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("sw_v200", {31'd0, instr_valid_o}, 32'd1);
        check("sw_i200", instr_o, 32'h0000_0013);
        check("sw_pc200", instr_pc_o, 32'h200);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("sw_vend", {31'd0, instr_valid_o}, 32'd0);

        // Backpressure / full
        set(1, 32'h204, 32'h4501_4501, 0, 0, 0);
        check("bp_r0", {31'd0, fetch_ready_o}, 32'd1);
        set(1, 32'h208, 32'h4501_4501, 0, 0, 0);
        check("bp_r2", {31'd0, fetch_ready_o}, 32'd1);
        check("bp_pc2", instr_pc_o, 32'h204);
        set(1, 32'h20C, 32'h0000_0013, 0, 0, 0);
        check("bp_rfull", {31'd0, fetch_ready_o}, 32'd0);
        check("bp_vfull", {31'd0, instr_valid_o}, 32'd1);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("bp_rhold", {31'd0, fetch_ready_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("bp_rrel1", {31'd0, fetch_ready_o}, {31'd0, ~RVC});
        check("bp_pcrel1", instr_pc_o, RVC ? 32'h206 : 32'h208);
        set(0, 32'h0, 32'h0, 0, 0, 0);
        check("bp_rrel2", {31'd0, fetch_ready_o}, 32'd1);
        check("bp_vrel2", {31'd0, instr_valid_o}, {31'd0, RVC});
        check("bp_pcrel2", instr_pc_o, RVC ? 32'h208 : 32'h20C);

        // Reset mid-stream
        set(1, 32'h20C, 32'h0000_0013, 0, 0, 0);
        set(0, 32'h0, 32'h0, 0, 0, 0);
        check("mrst_pre", {31'd0, instr_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mrst_v", {31'd0, instr_valid_o}, 32'd0);
        check("mrst_pc", instr_pc_o, 32'h0);
        check("mrst_i", instr_o, 32'h0);
        check("mrst_r", {31'd0, fetch_ready_o}, 32'd1);
        #2 rst_ni = 1'b1;
        set(1, 32'h0, 32'h0050_0093, 1, 0, 0);
        check("prst_v0", {31'd0, instr_valid_o}, 32'd0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("prst_i", instr_o, 32'h0050_0093);
        check("prst_pc", instr_pc_o, 32'h0);

        // PC wrap at the top of the address space
        set(0, 32'h0, 32'h0, 1, 1, 32'hFFFF_FFFC);
        set(1, 32'hFFFF_FFFC, 32'h0000_0013, 1, 0, 0);
        check("wr_v0", {31'd0, instr_valid_o}, 32'd0);
        set(1, 32'h0, 32'h0010_0093, 1, 0, 0);
        check("wr_i1", instr_o, 32'h0000_0013);
        check("wr_pc1", instr_pc_o, 32'hFFFF_FFFC);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("wr_i2", instr_o, 32'h0010_0093);
        check("wr_pc2", instr_pc_o, 32'h0);
        set(0, 32'h0, 32'h0, 1, 0, 0);
        check("wr_v3", {31'd0, instr_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
